adsr_envelope_poly: RTL
=======================

// Module: adsr_envelope_poly
// PURPOSE
//  Polyphonic ADSR envelope generator: NUM_VOICES independent envelopes sharing one A/D/S/R setting.
//  Width is generic; peak level is 2^(WIDTH-1)-1, so WIDTH=16 gives a peak of 0x7FFF.
//  Envelopes advance only on a sample-rate strobe (tick).
//  Sits between the key scanner/voice allocator and the per-voice amplitude multipliers.
//  Adds retrigger-from-current-level, saturating arithmetic and per-voice stage/active reporting.
// PARAMETERS
//  NUM_VOICES  4   number of independent envelope channels
//  WIDTH       16  envelope and rate width in bits; MAX = 2^(WIDTH-1)-1
//  REL_SHIFT   4   exponential-release shift; used only when ADSR_EXP_RELEASE_EN is defined
// PORTS
//  CLK     in   1                 clock
//  RESET   in   1                 synchronous, active-high reset
//  tick    in   1                 sample strobe; envelopes update only on cycles where tick=1
//  key_in  in   NUM_VOICES        per-voice gate, level-sensitive, sampled on tick
//  A       in   WIDTH             attack increment per tick
//  D       in   WIDTH             decay decrement per tick
//  S       in   WIDTH             sustain level, clamped to MAX
//  R       in   WIDTH             release decrement per tick
//  out     out  NUM_VOICES*WIDTH  envelope levels; voice v occupies [v*WIDTH +: WIDTH]
//  stage   out  NUM_VOICES*3      per-voice state code (see below)
//  active  out  NUM_VOICES        1 when voice state != IDLE
// BEHAVIOUR
//  - Clock and reset:
//    - Reset is synchronous and active-high (RESET on CLK).
//    - RESET has priority over tick and takes effect on any cycle.
//    - Reset values: all env=0, stage=IDLE, active=0, key_prev=0.
//  - Outputs are registered. A tick on cycle n is visible on out/stage/active at cycle n+1.
//  - On non-tick cycles all state holds.
//  - Per voice, on tick:
//    - k = key_in[v]; rise = k & ~key_prev[v].
//    - key_prev[v] <= k.
//    - Sc = min(S, MAX).
//  - Arithmetic is done in WIDTH+1 bits, unsigned, with no wrap-around; env never exceeds MAX.
//  - State codes:
//    - IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
//    - Codes 5-7 are illegal and recover to IDLE with env=0.
//  - IDLE:
//    - rise -> ATTACK; env unchanged (0).
//  - ATTACK:
//    - !k -> RELEASE; env held this tick.
//    - else if A==0 or env+A >= MAX -> env=MAX, go to DECAY.
//    - else env += A.
//  - DECAY:
//    - !k -> RELEASE; env held.
//    - else if D==0 or env <= Sc+D -> env=Sc, go to SUSTAIN.
//    - else env -= D.
//  - SUSTAIN:
//    - !k -> RELEASE.
//    - else env = Sc every tick, so live S changes are tracked.
//  - RELEASE:
//    - rise -> ATTACK; env kept (no click, attack continues from current level).
//    - else if R==0 or env <= R -> env=0, go to IDLE.
//    - else env -= R.
//  - Boundaries:
//    - A key held continuously never retriggers; a new attack needs a low tick followed by a high tick.
//    - Key high and low within a single tick interval is not seen.
//    - S >= MAX gives a decay that ends immediately at MAX.
//    - Voices are fully independent. A/D/S/R changes apply on the next tick.
//  - active[v] = (stage[v] != IDLE), registered alongside env.
// CONFIGURATION
//  ADSR_EXP_RELEASE_EN defined:
//   - RELEASE step = max(1, env >> REL_SHIFT); R is ignored.
//   - Terminates with env <= step -> env=0, IDLE.
//  ADSR_EXP_RELEASE_EN undefined:
//   - linear release using R as specified above.
//   - REL_SHIFT unused.
// TESTING (WIDTH=16, NUM_VOICES=4)
//  1. A=0x1000, key[0]=1, tick every 4 cycles -> out0 = 0x1000,0x2000..0x7000; 8th tick gives 0x7FFF, stage DECAY.
//  2. D=0x2000, S=0x4000, from 0x7FFF -> 0x5FFF, then 0x4000 with stage SUSTAIN; change S to 0x3000 -> next tick 0x3000.
//  3. key[0]=0, R=0x1000 from 0x4000 -> 0x3000,0x2000,0x1000,0x0000; stage IDLE; active[0]=0.
//  4. Release at 0x2800, key high again -> ATTACK from 0x2800 (A=0x1000 gives 0x3800); voices 1-3 undisturbed with out=0.
//  5. RESET mid-attack on a non-tick cycle -> next cycle all out=0, stage=0, active=0; held key re-attacks on the next tick.
//  6. ADSR_EXP_RELEASE_EN, REL_SHIFT=2, release from 0x4000 -> 0x3000, 0x2400; eventually 0x0000, IDLE.

Source files
------------

// File: rtl/adsr_envelope_poly.sv
// Polyphonic ADSR envelope generator: NUM_VOICES envelopes sharing one A/D/S/R setting, stepped on tick.
// Define ADSR_EXP_RELEASE_EN to replace the linear R-based release with an exponential env>>REL_SHIFT release.
module adsr_envelope_poly #(
    parameter int NUM_VOICES = 4,
    parameter int WIDTH      = 16,
    parameter int REL_SHIFT  = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          tick,
    input  logic [NUM_VOICES-1:0]         key_in,
    input  logic [WIDTH-1:0]              A,
    input  logic [WIDTH-1:0]              D,
    input  logic [WIDTH-1:0]              S,
    input  logic [WIDTH-1:0]              R,
    output logic [NUM_VOICES*WIDTH-1:0]   out,
    output logic [NUM_VOICES*3-1:0]       stage,
    output logic [NUM_VOICES-1:0]         active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // All arithmetic is one bit wider than the envelope so sums never wrap.
    localparam logic [WIDTH:0] MAX_W = {2'b00, {(WIDTH-1){1'b1}}};

    logic [WIDTH:0] a_w, d_w, s_w, sc_w, dec_lim_w;

    logic [2:0]       st_q   [NUM_VOICES];
    logic [2:0]       st_d   [NUM_VOICES];
    logic [WIDTH-1:0] env_q  [NUM_VOICES];
    logic [WIDTH-1:0] env_d  [NUM_VOICES];
    logic [WIDTH:0]   env_w  [NUM_VOICES];
    logic [WIDTH:0]   att_w  [NUM_VOICES];
    logic [WIDTH:0]   step_w [NUM_VOICES];
    logic [NUM_VOICES-1:0] kp_q, kp_d, act_q, act_d;

    assign a_w       = {1'b0, A};
    assign d_w       = {1'b0, D};
    assign s_w       = {1'b0, S};
    assign sc_w      = (s_w > MAX_W) ? MAX_W : s_w;
    assign dec_lim_w = sc_w + d_w;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign env_w[v] = {1'b0, env_q[v]};
        assign att_w[v] = env_w[v] + a_w;
`ifdef ADSR_EXP_RELEASE_EN
        // Exponential release never stalls: the step is at least one LSB.
        assign step_w[v] = ((env_w[v] >> REL_SHIFT) == '0) ? (WIDTH+1)'(1) : (env_w[v] >> REL_SHIFT);
`else
        assign step_w[v] = {1'b0, R};
`endif
        assign out[v*WIDTH +: WIDTH] = env_q[v];
        assign stage[v*3 +: 3]       = st_q[v];
        assign active[v]             = act_q[v];
    end

    always_comb begin
        st_d  = st_q;
        env_d = env_q;
        kp_d  = kp_q;
        act_d = act_q;
        if (tick) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                kp_d[v] = key_in[v];
                case (st_q[v])
                    IDLE: begin
                        if (key_in[v] && !kp_q[v]) st_d[v] = ATTACK;
                    end
                    ATTACK: begin
                        if (!key_in[v]) begin
                            st_d[v] = RELEASE;
                        end else if ((A == '0) || (att_w[v] >= MAX_W)) begin
                            env_d[v] = MAX_W[WIDTH-1:0];
                            st_d[v]  = DECAY;
                        end else begin
                            env_d[v] = att_w[v][WIDTH-1:0];
                        end
                    end
                    DECAY: begin
                        if (!key_in[v]) begin
                            st_d[v] = RELEASE;
                        end else if ((D == '0) || (env_w[v] <= dec_lim_w)) begin
                            env_d[v] = sc_w[WIDTH-1:0];
                            st_d[v]  = SUSTAIN;
                        end else begin
                            env_d[v] = env_q[v] - D;
                        end
                    end
                    SUSTAIN: begin
                        if (!key_in[v]) st_d[v] = RELEASE;
                        else            env_d[v] = sc_w[WIDTH-1:0];
                    end
                    RELEASE: begin
                        // Retrigger keeps the current level so the new attack starts without a click.
                        if (key_in[v] && !kp_q[v]) begin
                            st_d[v] = ATTACK;
                        end else if ((step_w[v] == '0) || (env_w[v] <= step_w[v])) begin
                            env_d[v] = '0;
                            st_d[v]  = IDLE;
                        end else begin
                            env_d[v] = env_q[v] - step_w[v][WIDTH-1:0];
                        end
                    end
                    default: begin
                        env_d[v] = '0;
                        st_d[v]  = IDLE;
                    end
                endcase
                act_d[v] = (st_d[v] != IDLE);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                st_q[v]  <= IDLE;
                env_q[v] <= '0;
            end
            kp_q  <= '0;
            act_q <= '0;
        end else begin
            st_q  <= st_d;
            env_q <= env_d;
            kp_q  <= kp_d;
            act_q <= act_d;
        end
    end

endmodule
